// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset sequencer.
package riscv_pkg;

  // Opcode field values (IR[6:0])
  localparam logic [6:0] OP_RT  = 7'b0110011;
  localparam logic [6:0] OP_IT  = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // State encoding
  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_EXEC    = 4'd2;
  localparam logic [3:0] ST_ALU_WB  = 4'd3;
  localparam logic [3:0] ST_ADDR    = 4'd4;
  localparam logic [3:0] ST_MEM     = 4'd5;
  localparam logic [3:0] ST_LOAD_WB = 4'd6;
  localparam logic [3:0] ST_BRANCH  = 4'd7;
  localparam logic [3:0] ST_TRAP    = 4'd8;

  typedef enum logic [3:0] {
    S_FETCH   = ST_FETCH,
    S_DECODE  = ST_DECODE,
    S_EXEC    = ST_EXEC,
    S_ALU_WB  = ST_ALU_WB,
    S_ADDR    = ST_ADDR,
    S_MEM     = ST_MEM,
    S_LOAD_WB = ST_LOAD_WB,
    S_BRANCH  = ST_BRANCH,
    S_TRAP    = ST_TRAP
  } state_t;

  // ALU operand selects and operation
  localparam logic       ASRC_PC  = 1'b0;
  localparam logic       ASRC_A   = 1'b1;
  localparam logic [1:0] BSRC_B   = 2'b00;
  localparam logic [1:0] BSRC_4   = 2'b01;
  localparam logic [1:0] BSRC_IMM = 2'b10;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FN   = 2'b10;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_BUS  = 2'b10;

  // Per-state control word; fetch is later qualified by mem_ready
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       fetch;
    logic       pc_write_cond;
    logic       pc_src;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [1:0] aluop;
    logic       regwrite;
    logic       memtoreg;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive unanswered memory-request cycles and flags a timeout
// once WAIT_LIMIT wait cycles have already elapsed without mem_ready.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  logic [7:0] r_cnt;
  logic       w_waiting;

  assign w_waiting = i_active & ~i_ready;
  // mem_ready in the limit cycle wins, so the flag requires ready low
  assign o_timeout = w_waiting && (r_cnt == LIMIT);

  // Count stalled request cycles; any completion or idle cycle restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (w_waiting && !o_timeout) r_cnt <= r_cnt + 8'd1;
    else                             r_cnt <= '0;
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Control FSM for a multi-cycle RV32I-subset datapath (R-type, ADDI, LW,
// SW, BEQ). Control outputs are registered from the next state, so they
// are all zero in reset and mem_req first rises one cycle after release.
module multicycle_sequencer
  import riscv_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_src,
  output logic             alusrc_a,
  output logic [1:0]       alusrc_b,
  output logic [1:0]       aluop,
  output logic             regwrite,
  output logic             memtoreg,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state, w_nxt;
  logic [6:0]       r_opcode, w_nxt_op;
  logic [1:0]       r_cause, w_nxt_cause;
  logic [CNT_W-1:0] r_instret;
  ctrl_t            r_ctrl;
  logic             w_retire;
  logic             w_timeout;
  logic             w_done;

  // Control word for a given state; opcode picks the EXEC/MEM flavour
  function automatic ctrl_t decode(input state_t s, input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req  = 1'b1;
        c.fetch    = 1'b1;
        c.alusrc_a = ASRC_PC;
        c.alusrc_b = BSRC_4;
        c.aluop    = ALU_ADD;
      end
      S_DECODE: begin
        c.alusrc_a = ASRC_PC;
        c.alusrc_b = BSRC_IMM;
        c.aluop    = ALU_ADD;
      end
      S_EXEC: begin
        c.alusrc_a = ASRC_A;
        if (op == OP_RT) begin
          c.alusrc_b = BSRC_B;
          c.aluop    = ALU_FN;
        end else begin
          c.alusrc_b = BSRC_IMM;
          c.aluop    = ALU_ADD;
        end
      end
      S_ALU_WB: c.regwrite = 1'b1;
      S_ADDR: begin
        c.alusrc_a = ASRC_A;
        c.alusrc_b = BSRC_IMM;
        c.aluop    = ALU_ADD;
      end
      S_MEM: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        c.mem_we  = (op == OP_SW);
      end
      S_LOAD_WB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_BRANCH: begin
        c.alusrc_a      = ASRC_A;
        c.alusrc_b      = BSRC_B;
        c.aluop         = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 1'b1;
      end
      S_TRAP:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_active  (r_ctrl.mem_req),
    .i_ready   (mem_ready),
    .o_timeout (w_timeout)
  );

  // mem_ready only counts while a request is actually on the bus
  assign w_done = r_ctrl.mem_req & mem_ready;

  // Next-state, opcode capture, trap cause and retire decisions
  always_comb begin
    w_nxt       = r_state;
    w_nxt_op    = r_opcode;
    w_nxt_cause = r_cause;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_done) w_nxt = S_DECODE;
        else if (w_timeout) begin
          w_nxt       = S_TRAP;
          w_nxt_cause = CAUSE_BUS;
        end
      end
      S_DECODE: begin
        w_nxt_op = opcode;
        case (opcode)
          OP_RT, OP_IT: w_nxt = S_EXEC;
          OP_LW, OP_SW: w_nxt = S_ADDR;
          OP_BEQ:       w_nxt = S_BRANCH;
          default: begin
            w_nxt       = S_TRAP;
            w_nxt_cause = CAUSE_ILL;
          end
        endcase
      end
      S_EXEC: w_nxt = S_ALU_WB;
      S_ALU_WB: begin
        w_nxt    = S_FETCH;
        w_retire = 1'b1;
      end
      S_ADDR: w_nxt = S_MEM;
      S_MEM: begin
        if (w_done) begin
          if (r_opcode == OP_LW) w_nxt = S_LOAD_WB;
          else begin
            w_nxt    = S_FETCH;
            w_retire = 1'b1;
          end
        end else if (w_timeout) begin
          w_nxt       = S_TRAP;
          w_nxt_cause = CAUSE_BUS;
        end
      end
      S_LOAD_WB, S_BRANCH: begin
        w_nxt    = S_FETCH;
        w_retire = 1'b1;
      end
      default: w_nxt = S_TRAP;
    endcase
  end

  // State, registered controls, trap cause and retired-instruction count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_cause   <= CAUSE_NONE;
      r_instret <= '0;
      r_ctrl    <= '0;
    end else begin
      r_state  <= w_nxt;
      r_opcode <= w_nxt_op;
      r_cause  <= w_nxt_cause;
      r_ctrl   <= decode(w_nxt, w_nxt_op);
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign mem_req       = r_ctrl.mem_req;
  assign mem_we        = r_ctrl.mem_we;
  assign iord          = r_ctrl.iord;
  assign ir_write      = r_ctrl.fetch & mem_ready;
  assign pc_write      = r_ctrl.fetch & mem_ready;
  assign pc_write_cond = r_ctrl.pc_write_cond;
  assign pc_src        = r_ctrl.pc_src;
  assign alusrc_a      = r_ctrl.alusrc_a;
  assign alusrc_b      = r_ctrl.alusrc_b;
  assign aluop         = r_ctrl.aluop;
  assign regwrite      = r_ctrl.regwrite;
  assign memtoreg      = r_ctrl.memtoreg;
  assign halted        = r_ctrl.halted;
  assign trap_cause    = r_cause;
  assign instret       = r_instret;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: each instruction pushes its
// expected per-cycle control vectors to a queue, which is drained cycle by
// cycle against the DUT. A 2-bit counter exercises instret wrap.
module tb_multicycle_sequencer;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic             pc_src, alusrc_a, regwrite, memtoreg, halted;
  logic [1:0]       alusrc_b, aluop, trap_cause;
  logic [CNT_W-1:0] instret;

  multicycle_sequencer #(.WAIT_LIMIT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop),
    .regwrite(regwrite), .memtoreg(memtoreg), .halted(halted),
    .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
  //  alusrc_a, alusrc_b[1:0], aluop[1:0], regwrite, memtoreg, halted}
  logic [14:0] w_vec;
  assign w_vec = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                  pc_src, alusrc_a, alusrc_b, aluop, regwrite, memtoreg, halted};

  localparam logic [14:0] V_IDLE  = 15'b0;
  localparam logic [14:0] V_FWAIT = {8'b1000_0000, 2'b01, 2'b00, 3'b000};
  localparam logic [14:0] V_FRDY  = {8'b1001_1000, 2'b01, 2'b00, 3'b000};
  localparam logic [14:0] V_DEC   = {8'b0000_0000, 2'b10, 2'b00, 3'b000};
  localparam logic [14:0] V_EXR   = {8'b0000_0001, 2'b00, 2'b10, 3'b000};
  localparam logic [14:0] V_EXI   = {8'b0000_0001, 2'b10, 2'b00, 3'b000};
  localparam logic [14:0] V_AWB   = {8'b0000_0000, 2'b00, 2'b00, 3'b100};
  localparam logic [14:0] V_ADDR  = {8'b0000_0001, 2'b10, 2'b00, 3'b000};
  localparam logic [14:0] V_MLW   = {8'b1010_0000, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] V_MSW   = {8'b1110_0000, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] V_LWB   = {8'b0000_0000, 2'b00, 2'b00, 3'b110};
  localparam logic [14:0] V_BR    = {8'b0000_0111, 2'b00, 2'b01, 3'b000};
  localparam logic [14:0] V_TRAP  = {8'b0000_0000, 2'b00, 2'b00, 3'b001};

  typedef struct {
    logic        rdy;
    logic [14:0] v;
  } step_t;

  step_t q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    exp_ret  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rdy, input logic [14:0] v, input int n);
    step_t s;
    s.rdy = rdy;
    s.v   = v;
    repeat (n) q.push_back(s);
  endtask

  // One queued step per cycle: drive mem_ready at negedge, compare just after
  task automatic drain(input string tag);
    step_t s;
    int    i;
    i = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      mem_ready = s.rdy;
      #1;
      chk($sformatf("%s[%0d]", tag, i), 32'(w_vec), 32'(s.v));
      i++;
    end
  endtask

  // Let the final edge of a sequence land, then look at counters
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] cause);
    chk({tag, "_instret"}, 32'(instret), 32'(exp_ret % (1 << CNT_W)));
    chk({tag, "_cause"}, 32'(trap_cause), 32'(cause));
  endtask

  // Async reset, check cleared outputs, release just after a posedge
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst       = 1'b1;
    mem_ready = 1'b0;
    #1;
    exp_ret = 0;
    chk({tag, "_vec"}, 32'(w_vec), 32'(V_IDLE));
    chk_state(tag, 2'b00);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    opcode    = 7'b0;
    #1;
    chk("reset_vec", 32'(w_vec), 32'(V_IDLE));
    chk_state("reset", 2'b00);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // First cycle after reset: no request, mem_ready must be ignored
    push(1'b1, V_IDLE, 1);
    // R-type, zero wait: 4 cycles
    opcode = 7'b0110011;
    push(1'b1, V_FRDY, 1); push(1'b1, V_DEC, 1);
    push(1'b1, V_EXR, 1);  push(1'b1, V_AWB, 1);
    drain("rtype");
    settle(); exp_ret++; chk_state("rtype", 2'b00);

    // LW with 3 wait cycles in MEM: 8 cycles
    opcode = 7'b0000011;
    push(1'b1, V_FRDY, 1); push(1'b1, V_DEC, 1); push(1'b1, V_ADDR, 1);
    push(1'b0, V_MLW, 3);  push(1'b1, V_MLW, 1); push(1'b1, V_LWB, 1);
    drain("lw");
    settle(); exp_ret++; chk_state("lw", 2'b00);

    // SW zero wait: 4 cycles
    opcode = 7'b0100011;
    push(1'b1, V_FRDY, 1); push(1'b1, V_DEC, 1);
    push(1'b1, V_ADDR, 1); push(1'b1, V_MSW, 1);
    drain("sw");
    settle(); exp_ret++; chk_state("sw", 2'b00);

    // BEQ zero wait: 3 cycles; instret wraps to 0 here
    opcode = 7'b1100011;
    push(1'b1, V_FRDY, 1); push(1'b1, V_DEC, 1); push(1'b1, V_BR, 1);
    drain("beq");
    settle(); exp_ret++; chk_state("beq_wrap", 2'b00);

    // ADDI with 2 fetch wait cycles
    opcode = 7'b0010011;
    push(1'b0, V_FWAIT, 2); push(1'b1, V_FRDY, 1); push(1'b1, V_DEC, 1);
    push(1'b1, V_EXI, 1);   push(1'b1, V_AWB, 1);
    drain("addi");
    settle(); exp_ret++; chk_state("addi", 2'b00);

    // Illegal opcode: trap after DECODE, no requests for 20 cycles
    opcode = 7'b1111111;
    push(1'b1, V_FRDY, 1); push(1'b1, V_DEC, 1); push(1'b1, V_TRAP, 20);
    drain("illegal");
    settle(); chk_state("illegal", 2'b01);

    // Fetch timeout: 16 stalled FETCH cycles then TRAP with bus cause
    do_reset("rst_a");
    push(1'b0, V_IDLE, 1); push(1'b0, V_FWAIT, 16); push(1'b1, V_TRAP, 3);
    drain("fetch_to");
    settle(); chk_state("fetch_to", 2'b10);

    // Ready on the 16th cycle wins over the timeout
    do_reset("rst_b");
    opcode = 7'b0110011;
    push(1'b0, V_IDLE, 1); push(1'b0, V_FWAIT, 15); push(1'b1, V_FRDY, 1);
    push(1'b1, V_DEC, 1);  push(1'b1, V_EXR, 1);    push(1'b1, V_AWB, 1);
    drain("fetch_edge");
    settle(); exp_ret++; chk_state("fetch_edge", 2'b00);

    // MEM timeout on a store: not retired
    opcode = 7'b0100011;
    push(1'b1, V_FRDY, 1); push(1'b1, V_DEC, 1); push(1'b1, V_ADDR, 1);
    push(1'b0, V_MSW, 16); push(1'b1, V_TRAP, 2);
    drain("mem_to");
    settle(); chk_state("mem_to", 2'b10);

    // Reset in the middle of a stalled SW access
    do_reset("rst_c");
    push(1'b0, V_IDLE, 1); push(1'b1, V_FRDY, 1); push(1'b1, V_DEC, 1);
    push(1'b1, V_ADDR, 1); push(1'b0, V_MSW, 2);
    drain("sw_pre");
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_iord", 32'(iord), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_ret = 0;
    push(1'b0, V_IDLE, 1); push(1'b0, V_FWAIT, 1);
    drain("midrst_post");
    chk_state("midrst", 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- FSM that sequences a multi-cycle RV32I-subset datapath (R-type, ADDI, LW, SW, BEQ). The datapath has one shared ALU, one unified instruction/data memory, and IR/A/B/ALUOut/MDR registers.
- Issues per-state datapath enables and mux selects.
- Runs a req/ready handshake to the shared memory with a wait timeout.
- Traps and halts on an illegal opcode or a memory timeout, and counts retired instructions.

Parameters:
WAIT_LIMIT, 15, max consecutive cycles mem_req may stay high without mem_ready before a bus trap (1..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
opcode  input  7  IR[6:0]; valid from the cycle after ir_write
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  1=write (SW), 0=read
iord  output  1  address select: 0=PC, 1=ALUOut
ir_write  output  1  load IR from memory read data
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (BEQ)
pc_src  output  1  0=ALU result, 1=ALUOut
alusrc_a  output  1  0=PC, 1=A register
alusrc_b  output  2  00=B, 01=constant 4, 10=immediate
aluop  output  2  00=add, 01=subtract, 10=funct-decoded
regwrite  output  1  register file write
memtoreg  output  1  write-back select: 0=ALUOut, 1=MDR
halted  output  1  FSM in TRAP
trap_cause  output  2  00=none, 01=illegal opcode, 10=bus timeout
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset, asynchronous, any state: state=FETCH, wait_cnt=0, instret=0, trap_cause=00. Mem_req rises one cycle after reset deasserts, not during reset. Every output not listed for a state is 0.
- Outputs are decoded from state and the registered opcode. Exceptions: ir_write and pc_write in FETCH are qualified by mem_ready.
- FETCH:
  - Drives mem_req=1, iord=0, alusrc_a=0, alusrc_b=01, aluop=00, pc_src=0.
  - On mem_ready: ir_write=1, pc_write=1, next state DECODE.
  - Otherwise stays in FETCH.
- DECODE:
  - Drives alusrc_a=0, alusrc_b=10, aluop=00, so the branch target goes to ALUOut.
  - Opcode registered here.
  - 0110011 or 0010011 -> EXEC; 0000011 or 0100011 -> ADDR; 1100011 -> BRANCH; any other opcode -> TRAP with cause 01.
- EXEC: alusrc_a=1. R-type: alusrc_b=00, aluop=10. ADDI: alusrc_b=10, aluop=00. Next ALU_WB.
- ALU_WB: regwrite=1, memtoreg=0. Next FETCH; instret++.
- ADDR: alusrc_a=1, alusrc_b=10, aluop=00. Next MEM.
- MEM:
  - Drives mem_req=1, iord=1, mem_we=1 for SW only.
  - On mem_ready: LW -> LOAD_WB; SW -> FETCH with instret++.
  - Otherwise stays in MEM.
- LOAD_WB: regwrite=1, memtoreg=1. Next FETCH; instret++.
- BRANCH: alusrc_a=1, alusrc_b=00, aluop=01, pc_write_cond=1, pc_src=1. Next FETCH; instret++.
- TRAP:
  - All enables 0, halted=1, trap_cause held.
  - Stays in TRAP until reset.
- Handshake:
  - mem_req, iord, mem_we and the address select stay stable until mem_ready is sampled high.
  - mem_ready sampled while mem_req=0 is ignored.
- Timeout:
  - wait_cnt increments each FETCH/MEM cycle where mem_ready=0 and clears when mem_ready=1 or the state changes.
  - When wait_cnt==WAIT_LIMIT with mem_ready=0: next state TRAP, cause 10.
  - If mem_ready arrives in that same cycle, mem_ready wins and the access completes.
- Latency with zero-wait memory: R/ADDI 4 cycles, LW 5, SW 4, BEQ 3. Each memory wait cycle adds 1.
- instret wraps modulo 2^CNT_W. A trapped instruction is not counted.
- Reset mid-access drops mem_req asynchronously. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package (riscv_pkg) holds:
  - opcode constants: RT, IT, LW, SW, BEQ;
  - state encoding localparams;
  - ALU src and aluop encodings;
  - trap cause codes.
- One natural sub-module: mem_wait_timer (wait_cnt plus timeout flag, parameterised by WAIT_LIMIT). The FSM stays in this block.

Test Plan:
1. Reset, then R-type (0110011) with mem_ready tied 1 -> states FETCH, DECODE, EXEC, ALU_WB over 4 cycles; regwrite=1, memtoreg=0 in cycle 4; instret=1.
2. LW with 3 wait cycles in MEM -> mem_req, iord=1, mem_we=0 held for 4 cycles; LOAD_WB has memtoreg=1; 8 cycles total; instret +1.
3. SW then BEQ, zero wait -> SW has mem_we=1 in MEM and takes 4 cycles; BEQ has pc_write_cond=1, aluop=01, pc_src=1 and takes 3 cycles; instret +2.
4. Opcode 1111111 -> TRAP after DECODE; halted=1, trap_cause=01; no mem_req for 20 cycles; instret unchanged.
5. mem_ready held 0 in FETCH with WAIT_LIMIT=15 -> TRAP after 16 FETCH cycles, cause 10. Second run: mem_ready=1 on the 16th cycle -> DECODE, no trap.
6. Assert rst mid-MEM of an SW -> mem_req and mem_we drop immediately; after release, FETCH in the next cycle; instret=0.
